// File: rtl/layer1_sequencer.sv
// Sequencer for the first conv layer: serial parameter load into per-channel
// kernel/BN registers, then one-frame pixel gating with output-count completion.
module layer1_sequencer #(
    parameter int DATA_WIDHT  = 32,
    parameter int IMG_WIDHT   = 220,
    parameter int IMG_HEIGHT  = 220,
    parameter int CHANNEL_OUT = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                Cfg_Start,
    input  logic [DATA_WIDHT-1:0]               Param_In,
    input  logic                                Param_Valid,
    output logic                                Param_Ready,
    input  logic                                Frame_Start,
    input  logic [DATA_WIDHT-1:0]               Pix_In,
    input  logic                                Pix_Valid,
    output logic                                Pix_Ready,
    output logic [DATA_WIDHT-1:0]               Layer_Data_In,
    output logic                                Layer_Valid_In,
    input  logic                                Layer_Valid_Out,
    output logic [DATA_WIDHT*9*CHANNEL_OUT-1:0] Kernel_Bus,
    output logic [DATA_WIDHT*CHANNEL_OUT-1:0]   BnA_Bus,
    output logic [DATA_WIDHT*CHANNEL_OUT-1:0]   BnB_Bus,
    output logic                                Params_Loaded,
    output logic                                Busy,
    output logic                                Frame_Done
);

    localparam int NPIX   = IMG_WIDHT * IMG_HEIGHT;
    localparam int NOUT   = (IMG_WIDHT - 2) * (IMG_HEIGHT - 2);
    localparam int CNT_W  = $clog2(NPIX + 1);
    localparam int CH_W   = (CHANNEL_OUT > 1) ? $clog2(CHANNEL_OUT) : 1;
    localparam int SLOT_W = 4;

    localparam logic [CNT_W-1:0]  PIX_LAST  = CNT_W'(NPIX - 1);
    localparam logic [CNT_W-1:0]  OUT_TOTAL = CNT_W'(NOUT);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(CHANNEL_OUT - 1);
    localparam logic [CH_W-1:0]   CH_ONE    = CH_W'(1);
    localparam logic [CH_W-1:0]   CH_ZERO   = CH_W'(0);
    localparam logic [SLOT_W-1:0] SLOT_A    = 4'd9;
    localparam logic [SLOT_W-1:0] SLOT_B    = 4'd10;
    localparam logic [SLOT_W-1:0] SLOT_ONE  = 4'd1;
    localparam logic [SLOT_W-1:0] SLOT_ZERO = 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_READY  = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   chan_q, chan_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic              loaded_q, loaded_d;
    logic              done_d, done_q;
    logic              param_ready_q, pix_ready_q, busy_q;
    logic              layer_valid_q;
    logic [DATA_WIDHT-1:0] layer_data_q;

    logic param_we_s;
    logic pix_acc_s;
    logic out_inc_s;

    logic [CHANNEL_OUT*9-1:0][DATA_WIDHT-1:0] kern_q;
    logic [CHANNEL_OUT-1:0][DATA_WIDHT-1:0]   bna_q;
    logic [CHANNEL_OUT-1:0][DATA_WIDHT-1:0]   bnb_q;

    // Handshake strobes derived from the registered ready flags.
    always_comb begin
        param_we_s = param_ready_q & Param_Valid;
        pix_acc_s  = pix_ready_q & Pix_Valid;
        if ((state_q == ST_STREAM) || (state_q == ST_DRAIN)) begin
            out_inc_s = Layer_Valid_Out;
        end else begin
            out_inc_s = 1'b0;
        end
    end

    // Next-state, load index, frame counters and completion decision.
    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        slot_d    = slot_q;
        pix_cnt_d = pix_cnt_q;
        loaded_d  = loaded_q;
        done_d    = 1'b0;
        if (out_inc_s) begin
            out_cnt_d = out_cnt_q + CNT_ONE;
        end else begin
            out_cnt_d = out_cnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (Cfg_Start) begin
                    state_d  = ST_LOAD;
                    chan_d   = CH_ZERO;
                    slot_d   = SLOT_ZERO;
                    loaded_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (param_we_s) begin
                    if (slot_q == SLOT_B) begin
                        slot_d = SLOT_ZERO;
                        if (chan_q == CH_LAST) begin
                            loaded_d = 1'b1;
                            state_d  = ST_READY;
                        end else begin
                            chan_d = chan_q + CH_ONE;
                        end
                    end else begin
                        slot_d = slot_q + SLOT_ONE;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_READY: begin
                // A reload request outranks a frame request in the same cycle.
                if (Cfg_Start) begin
                    state_d  = ST_LOAD;
                    chan_d   = CH_ZERO;
                    slot_d   = SLOT_ZERO;
                    loaded_d = 1'b0;
                end else if (Frame_Start) begin
                    state_d   = ST_STREAM;
                    pix_cnt_d = CNT_ZERO;
                    out_cnt_d = CNT_ZERO;
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_STREAM: begin
                if (pix_acc_s) begin
                    pix_cnt_d = pix_cnt_q + CNT_ONE;
                    if (pix_cnt_q == PIX_LAST) begin
                        if (out_cnt_d >= OUT_TOTAL) begin
                            done_d  = 1'b1;
                            state_d = ST_READY;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        state_d = ST_STREAM;
                    end
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                if (out_cnt_d >= OUT_TOTAL) begin
                    done_d  = 1'b1;
                    state_d = ST_READY;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered state-decode outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            chan_q        <= CH_ZERO;
            slot_q        <= SLOT_ZERO;
            pix_cnt_q     <= CNT_ZERO;
            out_cnt_q     <= CNT_ZERO;
            loaded_q      <= 1'b0;
            done_q        <= 1'b0;
            param_ready_q <= 1'b0;
            pix_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            chan_q        <= chan_d;
            slot_q        <= slot_d;
            pix_cnt_q     <= pix_cnt_d;
            out_cnt_q     <= out_cnt_d;
            loaded_q      <= loaded_d;
            done_q        <= done_d;
            param_ready_q <= (state_d == ST_LOAD);
            pix_ready_q   <= (state_d == ST_STREAM);
            busy_q        <= (state_d == ST_LOAD) || (state_d == ST_STREAM) ||
                             (state_d == ST_DRAIN);
        end
    end

    // Pixel forwarding stage: one cycle of latency, valid only on a handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            layer_valid_q <= 1'b0;
            layer_data_q  <= '0;
        end else begin
            layer_valid_q <= pix_acc_s;
            if (pix_acc_s) begin
                layer_data_q <= Pix_In;
            end else begin
                layer_data_q <= layer_data_q;
            end
        end
    end

    // Parameter word p lands in channel p/11, slot p%11 (0..8 kernel, 9 A, 10 B).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kern_q <= '0;
            bna_q  <= '0;
            bnb_q  <= '0;
        end else if (param_we_s) begin
            for (int c = 0; c < CHANNEL_OUT; c++) begin
                if (chan_q == CH_W'(c)) begin
                    for (int k = 0; k < 9; k++) begin
                        if (slot_q == SLOT_W'(k)) begin
                            kern_q[c*9+k] <= Param_In;
                        end
                    end
                    if (slot_q == SLOT_A) begin
                        bna_q[c] <= Param_In;
                    end
                    if (slot_q == SLOT_B) begin
                        bnb_q[c] <= Param_In;
                    end
                end
            end
        end else begin
            kern_q <= kern_q;
            bna_q  <= bna_q;
            bnb_q  <= bnb_q;
        end
    end

    assign Param_Ready    = param_ready_q;
    assign Pix_Ready      = pix_ready_q;
    assign Busy           = busy_q;
    assign Params_Loaded  = loaded_q;
    assign Frame_Done     = done_q;
    assign Layer_Valid_In = layer_valid_q;
    assign Layer_Data_In  = layer_data_q;
    assign Kernel_Bus     = kern_q;
    assign BnA_Bus        = bna_q;
    assign BnB_Bus        = bnb_q;

endmodule

// File: tb/tb_layer1_sequencer.sv
// Directed bench for layer1_sequencer on a 5x5 frame with a pixel scoreboard
// and a stub conv layer driving Layer_Valid_Out.
module tb_layer1_sequencer;

    localparam int DW   = 32;
    localparam int IW   = 5;
    localparam int IH   = 5;
    localparam int CH   = 8;
    localparam int NPIX = IW * IH;
    localparam int NOUT = (IW - 2) * (IH - 2);
    localparam int NPAR = 11 * CH;

    logic               clk = 1'b0;
    logic               rst;
    logic               Cfg_Start, Param_Valid, Param_Ready;
    logic [DW-1:0]      Param_In;
    logic               Frame_Start, Pix_Valid, Pix_Ready;
    logic [DW-1:0]      Pix_In;
    logic [DW-1:0]      Layer_Data_In;
    logic               Layer_Valid_In, Layer_Valid_Out;
    logic [DW*9*CH-1:0] Kernel_Bus;
    logic [DW*CH-1:0]   BnA_Bus, BnB_Bus;
    logic               Params_Loaded, Busy, Frame_Done;

    int n_assert = 0;
    int n_fail   = 0;
    int lv_cnt   = 0;
    int done_cnt = 0;
    bit hs_pending = 1'b0;
    logic [DW-1:0] sb_q[$];

    always #5 clk = ~clk;

    layer1_sequencer #(
        .DATA_WIDHT(DW), .IMG_WIDHT(IW), .IMG_HEIGHT(IH), .CHANNEL_OUT(CH)
    ) dut (
        .clk(clk), .rst(rst),
        .Cfg_Start(Cfg_Start), .Param_In(Param_In), .Param_Valid(Param_Valid),
        .Param_Ready(Param_Ready),
        .Frame_Start(Frame_Start), .Pix_In(Pix_In), .Pix_Valid(Pix_Valid),
        .Pix_Ready(Pix_Ready),
        .Layer_Data_In(Layer_Data_In), .Layer_Valid_In(Layer_Valid_In),
        .Layer_Valid_Out(Layer_Valid_Out),
        .Kernel_Bus(Kernel_Bus), .BnA_Bus(BnA_Bus), .BnB_Bus(BnB_Bus),
        .Params_Loaded(Params_Loaded), .Busy(Busy), .Frame_Done(Frame_Done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: each cycle's Layer_Valid_In must mirror the previous handshake.
    initial begin
        logic [DW-1:0] exp_pix;
        forever begin
            @(negedge clk);
            if (!rst) begin
                hs_pending = 1'b0;
            end else begin
                if (hs_pending || (Layer_Valid_In !== 1'b0)) begin
                    chk("layer_valid_in", {63'd0, Layer_Valid_In}, {63'd0, hs_pending});
                    if (hs_pending) begin
                        chk("scoreboard_has_entry", {63'd0, sb_q.size() != 0}, 64'd1);
                        exp_pix = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
                        chk("layer_data_in", {32'd0, Layer_Data_In}, {32'd0, exp_pix});
                    end
                end
                if (Layer_Valid_In === 1'b1) lv_cnt++;
                if (Frame_Done === 1'b1) done_cnt++;
                hs_pending = (Pix_Valid === 1'b1) && (Pix_Ready === 1'b1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout n_assert=%0d", n_assert);
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs();
        chk("rst_kernel_bus", {63'd0, |Kernel_Bus}, 64'd0);
        chk("rst_bna_bus", {63'd0, |BnA_Bus}, 64'd0);
        chk("rst_bnb_bus", {63'd0, |BnB_Bus}, 64'd0);
        chk("rst_layer_data", {32'd0, Layer_Data_In}, 64'd0);
        chk("rst_layer_valid", {63'd0, Layer_Valid_In}, 64'd0);
        chk("rst_pix_ready", {63'd0, Pix_Ready}, 64'd0);
        chk("rst_param_ready", {63'd0, Param_Ready}, 64'd0);
        chk("rst_params_loaded", {63'd0, Params_Loaded}, 64'd0);
        chk("rst_busy", {63'd0, Busy}, 64'd0);
        chk("rst_frame_done", {63'd0, Frame_Done}, 64'd0);
    endtask

    task automatic check_params(input int base);
        logic [DW*9*CH-1:0] exp_k;
        logic [DW*CH-1:0]   exp_a, exp_b;
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < 9; k++) exp_k[(c*9+k)*DW +: DW] = DW'(base + c*11 + k);
            exp_a[c*DW +: DW] = DW'(base + c*11 + 9);
            exp_b[c*DW +: DW] = DW'(base + c*11 + 10);
        end
        chk("kernel_bus", {63'd0, Kernel_Bus === exp_k}, 64'd1);
        chk("bna_bus", {63'd0, BnA_Bus === exp_a}, 64'd1);
        chk("bnb_bus", {63'd0, BnB_Bus === exp_b}, 64'd1);
        chk("ch0_k0", {32'd0, Kernel_Bus[0 +: DW]}, 64'(base));
        chk("ch0_B", {32'd0, BnB_Bus[0 +: DW]}, 64'(base + 10));
        chk("ch7_k8", {32'd0, Kernel_Bus[(7*9+8)*DW +: DW]}, 64'(base + 85));
        chk("ch7_A", {32'd0, BnA_Bus[7*DW +: DW]}, 64'(base + 86));
    endtask

    task automatic start_cfg();
        Cfg_Start = 1'b1;
        @(posedge clk); #1;
        Cfg_Start = 1'b0;
        chk("busy_load", {63'd0, Busy}, 64'd1);
    endtask

    task automatic load_words(input int base);
        for (int i = 0; i < NPAR; i++) begin
            Param_Valid = 1'b1;
            Param_In    = DW'(base + i);
            if (i == 0) chk("param_ready_load", {63'd0, Param_Ready}, 64'd1);
            if (i == NPAR - 1) chk("params_loaded_early", {63'd0, Params_Loaded}, 64'd0);
            @(posedge clk); #1;
        end
        Param_Valid = 1'b0;
        chk("params_loaded", {63'd0, Params_Loaded}, 64'd1);
        chk("param_ready_after", {63'd0, Param_Ready}, 64'd0);
        chk("busy_after_load", {63'd0, Busy}, 64'd0);
    endtask

    // One frame: start (or chained start), gappy pixels, stub outputs, completion.
    task automatic run_frame(input bit do_start, input bit drain_mode, input int inj_at,
                             input int abort_at, input logic [DW-1:0] base, input bit chain);
        int sent, outs, guard, first_out;
        bit inj_now, inj_done;
        sent = 0; outs = 0; guard = 0; inj_now = 1'b0; inj_done = 1'b0;
        first_out = drain_mode ? (NPIX - 5) : (NPIX - NOUT);
        if (do_start) Frame_Start = 1'b1;
        @(posedge clk); #1;
        Frame_Start = 1'b0;
        chk("pix_ready_start", {63'd0, Pix_Ready}, 64'd1);
        while (sent < NPIX && guard < 400) begin
            Cfg_Start = 1'b0; Frame_Start = 1'b0; Layer_Valid_Out = 1'b0;
            if (sent == abort_at) begin
                Pix_Valid = 1'b0;
                return;
            end
            if (sent == inj_at && !inj_done) begin
                Cfg_Start = 1'b1; Frame_Start = 1'b1; inj_now = 1'b1; inj_done = 1'b1;
            end
            Pix_Valid = ($urandom_range(0, 3) != 0);
            Pix_In    = base + DW'(sent);
            if (Pix_Valid && Pix_Ready) begin
                sb_q.push_back(Pix_In);
                if (sent >= first_out) begin
                    Layer_Valid_Out = 1'b1;
                    outs++;
                end
                sent++;
            end
            @(posedge clk); #1;
            guard++;
            if (inj_now) begin
                chk("stream_param_ready", {63'd0, Param_Ready}, 64'd0);
                chk("stream_busy", {63'd0, Busy}, 64'd1);
                chk("stream_params_loaded", {63'd0, Params_Loaded}, 64'd1);
                inj_now = 1'b0;
            end
        end
        Pix_Valid = 1'b0; Layer_Valid_Out = 1'b0; Cfg_Start = 1'b0; Frame_Start = 1'b0;
        chk("pixels_sent", 64'(sent), 64'(NPIX));
        chk("pix_ready_after_last", {63'd0, Pix_Ready}, 64'd0);
        while (outs < NOUT && guard < 400) begin
            Layer_Valid_Out = ($urandom_range(0, 1) != 0);
            if (Layer_Valid_Out) outs++;
            @(posedge clk); #1;
            guard++;
            Layer_Valid_Out = 1'b0;
            if (outs < NOUT) chk("frame_done_early", {63'd0, Frame_Done}, 64'd0);
        end
        chk("frame_done", {63'd0, Frame_Done}, 64'd1);
        if (chain) begin
            Frame_Start = 1'b1;
        end else begin
            @(posedge clk); #1;
            chk("frame_done_pulse", {63'd0, Frame_Done}, 64'd0);
        end
    endtask

    initial begin
        rst = 1'b0;
        Cfg_Start = 1'b0; Param_In = '0; Param_Valid = 1'b0;
        Frame_Start = 1'b0; Pix_In = '0; Pix_Valid = 1'b0; Layer_Valid_Out = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b1;
        @(posedge clk); #1;

        // Frame_Start without parameters is ignored.
        Frame_Start = 1'b1;
        @(posedge clk); #1;
        Frame_Start = 1'b0;
        chk("idle_pix_ready", {63'd0, Pix_Ready}, 64'd0);
        chk("idle_busy", {63'd0, Busy}, 64'd0);

        start_cfg();
        load_words(1);
        check_params(1);

        // Frame with mid-stream Cfg_Start/Frame_Start and outputs split over STREAM/DRAIN.
        run_frame(1'b1, 1'b1, 10, -1, 32'h0000_1000, 1'b0);
        chk("params_kept", {63'd0, Params_Loaded}, 64'd1);
        check_params(1);
        chk("frame_a_valid_count", 64'(lv_cnt), 64'(NPIX));
        chk("frame_a_done_count", 64'(done_cnt), 64'd1);

        // Simultaneous Cfg_Start and Frame_Start in READY: reload wins.
        Cfg_Start = 1'b1; Frame_Start = 1'b1;
        @(posedge clk); #1;
        Cfg_Start = 1'b0; Frame_Start = 1'b0;
        chk("both_param_ready", {63'd0, Param_Ready}, 64'd1);
        chk("both_params_loaded", {63'd0, Params_Loaded}, 64'd0);
        chk("both_pix_ready", {63'd0, Pix_Ready}, 64'd0);
        load_words(100);
        check_params(100);

        // Reset in the middle of a frame.
        run_frame(1'b1, 1'b1, -1, 12, 32'h0000_2000, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs();
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        lv_cnt = 0;
        done_cnt = 0;
        Frame_Start = 1'b1;
        @(posedge clk); #1;
        Frame_Start = 1'b0;
        chk("post_rst_pix_ready", {63'd0, Pix_Ready}, 64'd0);
        chk("post_rst_busy", {63'd0, Busy}, 64'd0);
        start_cfg();
        load_words(1);
        check_params(1);

        // Back-to-back frames: second Frame_Start in the Frame_Done cycle.
        run_frame(1'b1, 1'b0, -1, -1, 32'h0000_3000, 1'b1);
        run_frame(1'b0, 1'b1, -1, -1, 32'h0000_4000, 1'b0);
        @(posedge clk); #1;
        chk("b2b_valid_count", 64'(lv_cnt), 64'(2 * NPIX));
        chk("b2b_done_count", 64'(done_cnt), 64'd2);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/layer1_sequencer.md
# layer1_sequencer

Control block in front of the first convolution layer (8 parallel 3x3 stride-1 conv → batch-norm → ReLU channels). It loads and holds the per-channel kernel and batch-norm coefficients from a serial parameter stream. It then gates one image frame at a time from the pixel source into the layer and counts the layer's valid outputs to detect frame completion. Parameters are retained across frames until an explicit reload.

## Interface

Parameters:
- DATA_WIDHT, 32, width of every pixel, kernel and coefficient word
- IMG_WIDHT, 220, input frame width in pixels (≥3)
- IMG_HEIGHT, 220, input frame height in pixels (≥3)
- CHANNEL_OUT, 8, number of output channels driven with parameters

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset, asynchronous, active-low
- Cfg_Start  in  1  pulse: begin parameter load
- Param_In  in  DATA_WIDHT  parameter word
- Param_Valid  in  1  Param_In valid
- Param_Ready  out  1  sequencer accepts parameter word
- Frame_Start  in  1  pulse: begin one frame
- Pix_In  in  DATA_WIDHT  source pixel
- Pix_Valid  in  1  Pix_In valid
- Pix_Ready  out  1  sequencer accepts pixel
- Layer_Data_In  out  DATA_WIDHT  pixel to all conv channels
- Layer_Valid_In  out  1  Layer_Data_In valid
- Layer_Valid_Out  in  1  valid from channel-1 ReLU output (all channels aligned)
- Kernel_Bus  out  DATA_WIDHT*9*CHANNEL_OUT  word k (0..8) of channel c at [(c*9+k)*DATA_WIDHT +: DATA_WIDHT]
- BnA_Bus  out  DATA_WIDHT*CHANNEL_OUT  BN scale A of channel c at [c*DATA_WIDHT +: DATA_WIDHT]
- BnB_Bus  out  DATA_WIDHT*CHANNEL_OUT  BN offset B, same packing
- Params_Loaded  out  1  complete parameter set held
- Busy  out  1  high in LOAD, STREAM, DRAIN
- Frame_Done  out  1  one-cycle pulse at frame completion

## Operation

- States: IDLE, LOAD, READY, STREAM, DRAIN.
- IDLE: Cfg_Start → LOAD. Frame_Start ignored.
- LOAD:
  - Param_Ready=1.
  - Each Param_Valid&Param_Ready handshake stores one word at index p. p runs 0..11*CHANNEL_OUT-1 (88 by default).
  - Index p maps to channel c=p/11, slot s=p%11. s=0..8 → kernel word s; s=9 → A; s=10 → B.
  - After the last word: Params_Loaded=1, → READY.
  - Entering LOAD clears Params_Loaded and p. Register contents persist until overwritten.
  - Cfg_Start in LOAD is ignored.
- READY:
  - Cfg_Start → LOAD (reload).
  - Frame_Start → STREAM, clearing both counters.
  - If both are asserted in the same cycle, Cfg_Start wins.
- STREAM:
  - Pix_Ready=1 while pixel count < IMG_WIDHT*IMG_HEIGHT.
  - Each Pix_Valid&Pix_Ready handshake increments the pixel count.
  - On the accepting cycle of the last pixel → DRAIN.
- Output counting: Layer_Valid_Out increments the output count in both STREAM and DRAIN.
- DRAIN:
  - Pix_Ready=0.
  - When the output count reaches (IMG_WIDHT-2)*(IMG_HEIGHT-2), pulse Frame_Done and → READY.
  - If the final output arrives in the same cycle the last pixel is accepted, the pulse happens from STREAM directly.
- Cfg_Start and Frame_Start are ignored in STREAM and DRAIN.
- Extra Layer_Valid_Out outside STREAM/DRAIN is ignored.
- Counters are wide enough for IMG_WIDHT*IMG_HEIGHT. They do not wrap within a frame.

## Timing

- Reset (rst=0, async):
  - State=IDLE; all counters 0.
  - Every output is 0: all buses, Layer_Data_In, Layer_Valid_In, Pix_Ready, Param_Ready, Params_Loaded, Busy, Frame_Done.
- Reset mid-frame or mid-load aborts immediately. Stored parameters are cleared.
- Param_Ready, Pix_Ready and Busy are registered state decodes.
  - Param_Ready is high the cycle after Cfg_Start is sampled.
  - Pix_Ready is high the cycle after Frame_Start is sampled.
- A parameter word accepted at edge t appears on its bus after edge t.
- Params_Loaded is high the cycle after the last word is accepted.
- Pixel path is registered, latency 1:
  - Layer_Data_In/Layer_Valid_In at edge t+1 reflect the handshake at edge t.
  - Layer_Valid_In=0 in cycles with no handshake.
- Source backpressure (Pix_Valid low) inserts bubbles. Counting is unaffected.
- Frame_Done is registered and high for exactly one cycle, after the edge that counts the last output.
- READY is reached on the same edge, so a Frame_Start on the next cycle begins a new frame (back-to-back frames).

## Test plan

- Load 88 words with values 1..88, Param_Valid held high, then idle:
  - channel 0 kernel words = 1..9, A=10, B=11;
  - channel 7 kernel words = 78..86, A=87, B=88;
  - Params_Loaded rises 1 cycle after word 88; Param_Ready low afterwards.
- Parameters, IMG 5x5; stream 25 pixels with random Pix_Valid gaps; stub layer returns 9 Layer_Valid_Out pulses:
  - exactly 25 Layer_Valid_In pulses, each 1 cycle after its handshake, data in order;
  - Pix_Ready=0 after pixel 25;
  - one Frame_Done after the 9th output.
- In STREAM: assert Cfg_Start and Frame_Start → no effect; pixel count, Params_Loaded and buses unchanged.
- In READY: Cfg_Start and Frame_Start in the same cycle → LOAD entered, Params_Loaded=0, Pix_Ready stays 0.
- Drop rst at pixel 12 of 25 → all outputs 0 asynchronously. After release, Frame_Start is ignored until a full 88-word reload.
- Two back-to-back 5x5 frames, Frame_Start the cycle after Frame_Done → second frame accepted with no idle gap; 2 Frame_Done pulses total.
